key_schedule_ctrl: RTL and testbench
====================================

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 The block SHALL have parameter NK, default 4, giving the key length in 32-bit words; legal values are 4, 6 and 8 (AES-128/192/256).
REQ-002 The block SHALL have derived parameters NR = NK+6, the number of rounds, and NW = 4*(NR+1), the total number of schedule words (44/52/60).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to expand key_in.
REQ-006 The block SHALL have port key_in, input, NK*32 bits: the cipher key; bits [NK*32-1 -: 32] are word w0.
REQ-007 The block SHALL have port rk_idx, input, 4 bits: the round-key index, 0..NR.
REQ-008 The block SHALL have port rk_out, output, 128 bits: round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs.
REQ-009 The block SHALL have port rk_valid, output, 1 bit: rk_out is valid for the rk_idx sampled on the previous edge.
REQ-010 The block SHALL have port busy, output, 1 bit: an expansion is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse when expansion completes.
REQ-012 The block SHALL have port ready, output, 1 bit: the stored schedule is complete and readable.

Function
REQ-013 The block SHALL hold an NW x 32-bit word store; one KeyExpansion-equivalent step (NK words in, NK words out, Rcon input) SHALL be instantiated once and reused every step.
REQ-014 The block SHALL implement states IDLE, EXPAND and FINISH.
- IDLE -> EXPAND on start.
- EXPAND -> FINISH after the last step.
- FINISH -> IDLE unconditionally.
REQ-015 When start is accepted in IDLE, at that edge the block SHALL write w0..w[NK-1] from key_in, clear step counter s to 0, set busy=1 and clear ready.
REQ-016 On each EXPAND edge the block SHALL apply the step to words w[s*NK .. s*NK+NK-1] with Rcon = {RC[s], 24'h0}, write the results to w[(s+1)*NK ..], and increment s.
REQ-017 The block SHALL use RC[s] = 01,02,04,08,10,20,40,80,1B,36 for s = 0..9; s never exceeds 9.
REQ-018 The number of steps SHALL be S = ceil((NW-NK)/NK): 10, 8 and 7 for NK = 4, 6, 8.
REQ-019 Result words with index >= NW SHALL be discarded; no store write out of range.
REQ-020 The block SHALL set done=1 for exactly the one cycle in FINISH; at the FINISH->IDLE edge, busy->0 and ready->1, and ready SHALL stay 1 until the next accepted start.
REQ-021 Latency SHALL be S+2 edges from the start edge until ready=1, i.e. 12 for NK=4.
REQ-022 A start asserted while busy=1 SHALL be ignored, with no effect on the store, s or the outputs.
REQ-023 A start in IDLE with ready=1 SHALL restart the expansion; the old schedule is invalid from that edge (ready=0).
REQ-024 Reads SHALL have one-edge latency: rk_out and rk_valid are registered from the rk_idx sampled on an edge.
- rk_valid = ready AND (rk_idx <= NR).
- rk_out = 0 when rk_valid would be 0.
REQ-025 Reads SHALL be allowed in every state and SHALL never stall expansion; an out-of-range rk_idx SHALL give rk_valid=0 and rk_out=0.

Reset
REQ-026 On rst_n=0, asynchronously:
- state = IDLE and s = 0;
- busy, done, ready, rk_valid = 0;
- rk_out = 0.
The word store need not be cleared.
REQ-027 A reset asserted mid-expansion SHALL abort it; after release the block SHALL sit in IDLE with ready=0 until a new start is accepted.

Verification
REQ-028 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, start -> done after 11 edges, ready after 12; then rk_idx=0 -> 2b7e1516..09cf4f3c and rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_valid=1.
REQ-029 NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_idx=12 returns e98ba06f448c773c8ecc720401002202; rk_idx=13 -> rk_valid=0, rk_out=0.
REQ-030 NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_idx=14 returns fe4890d1e6188d0b046df344706c631e; total latency 9 edges.
REQ-031 NK=4, second start 3 cycles into EXPAND with a different key -> ignored; the final schedule matches the first key and done pulses once.
REQ-032 NK=4, rst_n low for 1 cycle at step 5 -> busy, ready, done = 0 immediately; no done pulse follows; a subsequent start expands correctly.
REQ-033 Read rk_idx=3 on every cycle during expansion -> rk_valid=0 throughout; first rk_valid=1 on the edge after ready rises.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: iterative AES key expansion (NK = 4/6/8) into a word store,
// with a one-edge-latency round-key read port that is usable in every state.
module key_schedule_ctrl #(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = NK + 6,
  parameter int unsigned NW = 4 * (NR + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NK*32-1:0]  key_in,
  input  logic [3:0]        rk_idx,
  output logic [127:0]      rk_out,
  output logic              rk_valid,
  output logic              busy,
  output logic              done,
  output logic              ready
);

  localparam int unsigned AW = $clog2(NW);
  localparam int unsigned SW = 4;
  localparam int unsigned S  = (NW - NK + NK - 1) / NK;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int k = 2; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [SW-1:0] s);
    logic [7:0] rc;
    case (s)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_s;
  logic            w_start_acc;
  logic            w_last_step;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_ready_nxt;
  logic            r_busy;
  logic            r_done;
  logic            r_ready;
  logic            r_rk_valid;
  logic [127:0]    r_rk_out;
  logic [31:0]     r_w     [NW];
  logic [31:0]     w_w_nxt [NW];
  logic [31:0]     w_old   [NK];
  logic [31:0]     w_new   [NK];
  logic [AW-1:0]   w_rd_base;
  logic            w_rd_hit;
  logic [AW-1:0]   w_rk_base;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_last_step = (r_s == SW'(S - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_EXPAND;
      ST_EXPAND: if (w_last_step) w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered status outputs
  always_comb begin
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = (w_state_nxt == ST_FINISH);
    w_ready_nxt = r_ready;
    if (w_start_acc)                 w_ready_nxt = 1'b0;
    else if (r_state == ST_FINISH)   w_ready_nxt = 1'b1;
  end

  // Status output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Step counter; wraps to 0 on the last step so it never exceeds S-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_s <= '0;
    else if (w_start_acc)          r_s <= '0;
    else if (r_state == ST_EXPAND) r_s <= w_last_step ? '0 : r_s + SW'(1);
  end

  // One key-expansion step: NK words of block s produce NK words of block s+1
  always_comb begin
    logic [31:0] v_prev;
    logic [31:0] v_temp;
    w_rd_base = AW'(32'(r_s) * NK);
    for (int unsigned k = 0; k < NK; k++) begin
      w_old[k] = r_w[w_rd_base + AW'(k)];
    end
    v_prev = w_old[NK-1];
    for (int unsigned k = 0; k < NK; k++) begin
      v_temp = v_prev;
      if (k == 0)
        v_temp = sub_word({v_prev[23:0], v_prev[31:24]}) ^ {rcon(r_s), 24'h0};
      else if ((NK > 6) && (k == 4))
        v_temp = sub_word(v_prev);
      w_new[k] = w_old[k] ^ v_temp;
      v_prev   = w_new[k];
    end
  end

  // Next store contents: key load on accepted start, step results during EXPAND
  always_comb begin
    w_w_nxt = r_w;
    if (w_start_acc) begin
      for (int unsigned k = 0; k < NK; k++) begin
        w_w_nxt[AW'(k)] = key_in[NK*32 - 1 - 32*k -: 32];
      end
    end else if (r_state == ST_EXPAND) begin
      for (int unsigned k = 0; k < NK; k++) begin
        if ((32'(r_s) + 1) * NK + k < NW)
          w_w_nxt[AW'((32'(r_s) + 1) * NK + k)] = w_new[k];
      end
    end
  end

  // Word store; contents are undefined until loaded, so no reset
  always_ff @(posedge clk) begin
    r_w <= w_w_nxt;
  end

  assign w_rd_hit  = r_ready && (rk_idx <= 4'(NR));
  assign w_rk_base = AW'(32'(w_rd_hit ? rk_idx : 4'd0) * 4);

  // Round-key read port, one edge of latency, zero when not valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk_valid <= 1'b0;
      r_rk_out   <= '0;
    end else begin
      r_rk_valid <= w_rd_hit;
      r_rk_out   <= w_rd_hit ? {r_w[w_rk_base], r_w[w_rk_base + AW'(1)],
                                r_w[w_rk_base + AW'(2)], r_w[w_rk_base + AW'(3)]}
                             : 128'h0;
    end
  end

  assign rk_out   = r_rk_out;
  assign rk_valid = r_rk_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ready    = r_ready;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl: directed vectors for NK = 4, 6 and 8 instances.
module tb_key_schedule_ctrl;

  localparam logic [127:0] K4   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R4_1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R4_2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R4_3 = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] R4_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K6   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] R6_0 = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R6_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K8   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R8_0 = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R8_1 = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R8_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         s4, s6, s8;
  logic [127:0] k4;
  logic [191:0] k6;
  logic [255:0] k8;
  logic [3:0]   i4, i6, i8;
  logic [127:0] o4, o6, o8;
  logic         v4, v6, v8, b4, b6, b8, d4, d6, d8, r4, r6, r8;

  key_schedule_ctrl #(.NK(4)) u4 (.clk(clk), .rst_n(rst_n), .start(s4), .key_in(k4), .rk_idx(i4),
    .rk_out(o4), .rk_valid(v4), .busy(b4), .done(d4), .ready(r4));
  key_schedule_ctrl #(.NK(6)) u6 (.clk(clk), .rst_n(rst_n), .start(s6), .key_in(k6), .rk_idx(i6),
    .rk_out(o6), .rk_valid(v6), .busy(b6), .done(d6), .ready(r6));
  key_schedule_ctrl #(.NK(8)) u8 (.clk(clk), .rst_n(rst_n), .start(s8), .key_in(k8), .rk_idx(i8),
    .rk_out(o8), .rk_valid(v8), .busy(b8), .done(d8), .ready(r8));

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int           nk;
    logic [3:0]   idx;
    logic         vld;
    logic [127:0] out;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fd4, fd6, fd8, fr4, fr6, fr8, nd4, nd6, nd8, fv4, bad_v;
    logic [127:0] a_out;
    logic         a_vld;

    tbl[0]  = '{4, 4'd0,  1'b1, K4};
    tbl[1]  = '{4, 4'd1,  1'b1, R4_1};
    tbl[2]  = '{4, 4'd2,  1'b1, R4_2};
    tbl[3]  = '{4, 4'd10, 1'b1, R4_10};
    tbl[4]  = '{4, 4'd11, 1'b0, 128'h0};
    tbl[5]  = '{4, 4'd15, 1'b0, 128'h0};
    tbl[6]  = '{6, 4'd0,  1'b1, R6_0};
    tbl[7]  = '{6, 4'd12, 1'b1, R6_12};
    tbl[8]  = '{6, 4'd13, 1'b0, 128'h0};
    tbl[9]  = '{8, 4'd0,  1'b1, R8_0};
    tbl[10] = '{8, 4'd1,  1'b1, R8_1};
    tbl[11] = '{8, 4'd14, 1'b1, R8_14};
    tbl[12] = '{8, 4'd15, 1'b0, 128'h0};

    // Reset state
    rst_n = 1'b0;
    s4 = 1'b0; s6 = 1'b0; s8 = 1'b0;
    k4 = '0; k6 = '0; k8 = '0;
    i4 = 4'd0; i6 = 4'd0; i8 = 4'd0;
    tick();
    tick();
    chk("rst_busy",  128'(b4), 128'd0);
    chk("rst_done",  128'(d4), 128'd0);
    chk("rst_ready", 128'({r4, r6, r8}), 128'd0);
    chk("rst_valid", 128'(v4), 128'd0);
    chk("rst_out",   o4, 128'h0);
    rst_n = 1'b1;
    tick();

    // Expand all three widths together; track latency and read-during-expand
    k4 = K4; k6 = K6; k8 = K8;
    s4 = 1'b1; s6 = 1'b1; s8 = 1'b1;
    i4 = 4'd3;
    fd4 = 0; fd6 = 0; fd8 = 0; fr4 = 0; fr6 = 0; fr8 = 0;
    nd4 = 0; nd6 = 0; nd8 = 0; fv4 = 0; bad_v = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 1) begin
        s4 = 1'b0; s6 = 1'b0; s8 = 1'b0;
        chk("busy_at_start", 128'(b4), 128'd1);
      end
      if (d4) begin nd4++; if (fd4 == 0) fd4 = e; end
      if (d6) begin nd6++; if (fd6 == 0) fd6 = e; end
      if (d8) begin nd8++; if (fd8 == 0) fd8 = e; end
      if (r4 && fr4 == 0) fr4 = e;
      if (r6 && fr6 == 0) fr6 = e;
      if (r8 && fr8 == 0) fr8 = e;
      if (v4 && fv4 == 0) fv4 = e;
      if (v4 && !r4) bad_v++;
    end
    chk("nk4_done_edge",  128'(fd4), 128'd11);
    chk("nk4_ready_edge", 128'(fr4), 128'd12);
    chk("nk4_done_count", 128'(nd4), 128'd1);
    chk("nk6_done_edge",  128'(fd6), 128'd9);
    chk("nk6_ready_edge", 128'(fr6), 128'd10);
    chk("nk6_done_count", 128'(nd6), 128'd1);
    chk("nk8_done_edge",  128'(fd8), 128'd8);
    chk("nk8_ready_edge", 128'(fr8), 128'd9);
    chk("nk8_done_count", 128'(nd8), 128'd1);
    chk("first_valid_edge", 128'(fv4), 128'd13);
    chk("valid_while_busy", 128'(bad_v), 128'd0);
    chk("busy_after_done", 128'(b4), 128'd0);
    chk("rk3_out", o4, R4_3);

    // Table-driven round-key reads
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].nk == 4)      i4 = tbl[i].idx;
      else if (tbl[i].nk == 6) i6 = tbl[i].idx;
      else                     i8 = tbl[i].idx;
      tick();
      if (tbl[i].nk == 4)      begin a_out = o4; a_vld = v4; end
      else if (tbl[i].nk == 6) begin a_out = o6; a_vld = v6; end
      else                     begin a_out = o8; a_vld = v8; end
      chk($sformatf("tbl%0d_valid", i), 128'(a_vld), 128'(tbl[i].vld));
      chk($sformatf("tbl%0d_out", i), a_out, tbl[i].out);
    end

    // Restart from ready, then a second start mid-expansion that must be ignored
    k4 = K4; s4 = 1'b1;
    tick();
    s4 = 1'b0;
    chk("restart_ready_clear", 128'(r4), 128'd0);
    tick(); tick(); tick();
    k4 = {4{32'hffffffff}}; s4 = 1'b1;
    tick();
    s4 = 1'b0; k4 = '0;
    chk("ignored_start_busy", 128'(b4), 128'd1);
    nd4 = 0; fr4 = 0;
    for (int e = 6; e <= 20; e++) begin
      tick();
      if (d4) nd4++;
      if (r4 && fr4 == 0) fr4 = e;
    end
    chk("ignored_done_count", 128'(nd4), 128'd1);
    chk("ignored_ready_edge", 128'(fr4), 128'd12);
    i4 = 4'd10;
    tick();
    chk("ignored_rk10", o4, R4_10);
    i4 = 4'd1;
    tick();
    chk("ignored_rk1", o4, R4_1);

    // Reset in the middle of expansion
    k4 = K4; s4 = 1'b1;
    tick();
    s4 = 1'b0;
    for (int e = 0; e < 5; e++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_status", 128'({b4, r4, d4}), 128'd0);
    tick();
    rst_n = 1'b1;
    nd4 = 0; fr4 = 0;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (d4) nd4++;
      if (r4) fr4++;
    end
    chk("midrst_no_done",  128'(nd4), 128'd0);
    chk("midrst_no_ready", 128'(fr4), 128'd0);
    k4 = K4; s4 = 1'b1;
    tick();
    s4 = 1'b0;
    fr4 = 0;
    for (int e = 0; e < 20 && fr4 == 0; e++) begin
      tick();
      if (r4) fr4 = 1;
    end
    chk("midrst_ready_reached", 128'(fr4), 128'd1);
    i4 = 4'd10;
    tick();
    chk("midrst_rk10_valid", 128'(v4), 128'd1);
    chk("midrst_rk10", o4, R4_10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
